// File: rtl/mips_control_unit.sv
// -----------------------------------------------------------------------------
// mips_control_unit
//
// Multicycle MIPS control unit. It is a Moore FSM: a state register plus
// combinational output decode from the current state. Only the EXECUTE ALU
// operation (from funct) and the BRANCH PC enable (from zero) also look at
// the instruction fields.
//
// Optional feature:
//   MIPS_CU_BNE_EN - when defined, BNE (opcode 000101) follows the BEQ path
//                    and branches when zero==0. When undefined, BNE is an
//                    unsupported opcode.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   opcode[5:0]  in   IR[31:26], held stable from DECODE onward
//   funct[5:0]   in   IR[5:0]
//   zero         in   ALU zero flag
//   pc_en        out  PC register enable
//   iord         out  memory address select (1 = ALUOut)
//   mem_write    out  data memory write
//   ir_write     out  IR load
//   reg_dst      out  register file write address select (1 = rd)
//   mem_to_reg   out  register file write data select (1 = memory data)
//   reg_write    out  register file write enable
//   alu_src_a    out  ALU A select (1 = register A)
//   alu_src_b    out  ALU B select: 00 B, 01 const 4, 10 signext imm, 11 imm<<2
//   alu_control  out  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
//   pc_src       out  next PC select: 00 ALU, 01 ALUOut, 10 jump target
//   illegal      out  one-cycle pulse in DECODE for an unsupported opcode
//   state        out  current state, for debug
// -----------------------------------------------------------------------------
module mips_control_unit #(
   parameter int STATE_WIDTH = 4,
   parameter int OPC_WIDTH   = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [OPC_WIDTH-1:0]   opcode,
   input  logic [OPC_WIDTH-1:0]   funct,
   input  logic                   zero,
   output logic                   pc_en,
   output logic                   iord,
   output logic                   mem_write,
   output logic                   ir_write,
   output logic                   reg_dst,
   output logic                   mem_to_reg,
   output logic                   reg_write,
   output logic                   alu_src_a,
   output logic [1:0]             alu_src_b,
   output logic [2:0]             alu_control,
   output logic [1:0]             pc_src,
   output logic                   illegal,
   output logic [STATE_WIDTH-1:0] state
);

   // ---------------------------------------------------------------------
   // Opcode / funct / ALU encodings
   // ---------------------------------------------------------------------
   localparam logic [OPC_WIDTH-1:0] OP_RTYPE = OPC_WIDTH'(6'b000000);
   localparam logic [OPC_WIDTH-1:0] OP_LW    = OPC_WIDTH'(6'b100011);
   localparam logic [OPC_WIDTH-1:0] OP_SW    = OPC_WIDTH'(6'b101011);
   localparam logic [OPC_WIDTH-1:0] OP_BEQ   = OPC_WIDTH'(6'b000100);
   localparam logic [OPC_WIDTH-1:0] OP_ADDI  = OPC_WIDTH'(6'b001000);
   localparam logic [OPC_WIDTH-1:0] OP_J     = OPC_WIDTH'(6'b000010);

   localparam logic [OPC_WIDTH-1:0] FN_ADD   = OPC_WIDTH'(6'b100000);
   localparam logic [OPC_WIDTH-1:0] FN_SUB   = OPC_WIDTH'(6'b100010);
   localparam logic [OPC_WIDTH-1:0] FN_AND   = OPC_WIDTH'(6'b100100);
   localparam logic [OPC_WIDTH-1:0] FN_OR    = OPC_WIDTH'(6'b100101);
   localparam logic [OPC_WIDTH-1:0] FN_SLT   = OPC_WIDTH'(6'b101010);

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ---------------------------------------------------------------------
   // State encoding (codes 12-15 are unused and recover to FETCH)
   // ---------------------------------------------------------------------
   typedef enum logic [STATE_WIDTH-1:0] {
      S_FETCH   = STATE_WIDTH'(0),
      S_DECODE  = STATE_WIDTH'(1),
      S_MEMADR  = STATE_WIDTH'(2),
      S_MEMRD   = STATE_WIDTH'(3),
      S_MEMWB   = STATE_WIDTH'(4),
      S_MEMWR   = STATE_WIDTH'(5),
      S_EXECUTE = STATE_WIDTH'(6),
      S_ALUWB   = STATE_WIDTH'(7),
      S_BRANCH  = STATE_WIDTH'(8),
      S_ADDIEX  = STATE_WIDTH'(9),
      S_ADDIWB  = STATE_WIDTH'(10),
      S_JUMP    = STATE_WIDTH'(11)
   } state_t;

   state_t r_state;
   state_t w_state_eff;
   state_t w_decode_next;

   logic w_is_lw;
   logic w_is_sw;
   logic w_is_rtype;
   logic w_is_beq;
   logic w_is_bne;
   logic w_is_addi;
   logic w_is_j;
   logic w_op_legal;
   logic w_branch_taken;

   logic [2:0] w_funct_alu;

   logic       w_pc_write;
   logic       w_iord;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_reg_dst;
   logic       w_mem_to_reg;
   logic       w_reg_write;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [2:0] w_alu_control;
   logic [1:0] w_pc_src;
   logic       w_illegal;

   // ---------------------------------------------------------------------
   // Opcode classification
   // ---------------------------------------------------------------------
   assign w_is_lw    = (opcode == OP_LW);
   assign w_is_sw    = (opcode == OP_SW);
   assign w_is_rtype = (opcode == OP_RTYPE);
   assign w_is_beq   = (opcode == OP_BEQ);
   assign w_is_addi  = (opcode == OP_ADDI);
   assign w_is_j     = (opcode == OP_J);

`ifdef MIPS_CU_BNE_EN
   localparam logic [OPC_WIDTH-1:0] OP_BNE = OPC_WIDTH'(6'b000101);
   assign w_is_bne = (opcode == OP_BNE);
`else
   assign w_is_bne = 1'b0;
`endif

   assign w_op_legal = w_is_lw | w_is_sw | w_is_rtype | w_is_beq |
                       w_is_bne | w_is_addi | w_is_j;

   // BEQ branches on zero, BNE on not-zero; both share the BRANCH state.
   assign w_branch_taken = w_is_bne ? ~zero : zero;

   // ---------------------------------------------------------------------
   // DECODE dispatch target
   // ---------------------------------------------------------------------
   always_comb begin
      w_decode_next = S_FETCH;
      if (w_is_lw || w_is_sw) begin
         w_decode_next = S_MEMADR;
      end else if (w_is_rtype) begin
         w_decode_next = S_EXECUTE;
      end else if (w_is_beq || w_is_bne) begin
         w_decode_next = S_BRANCH;
      end else if (w_is_addi) begin
         w_decode_next = S_ADDIEX;
      end else if (w_is_j) begin
         w_decode_next = S_JUMP;
      end
   end

   // ---------------------------------------------------------------------
   // State register and transitions
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:   r_state <= S_DECODE;
            S_DECODE:  r_state <= w_decode_next;
            S_MEMADR:  r_state <= w_is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:   r_state <= S_MEMWB;
            S_EXECUTE: r_state <= S_ALUWB;
            S_ADDIEX:  r_state <= S_ADDIWB;
            S_MEMWB,
            S_MEMWR,
            S_ALUWB,
            S_BRANCH,
            S_ADDIWB,
            S_JUMP:    r_state <= S_FETCH;
            default:   r_state <= S_FETCH;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // R-type funct to ALU operation; unknown functs fall back to add
   // ---------------------------------------------------------------------
   always_comb begin
      w_funct_alu = ALU_ADD;
      case (funct)
         FN_ADD:  w_funct_alu = ALU_ADD;
         FN_SUB:  w_funct_alu = ALU_SUB;
         FN_AND:  w_funct_alu = ALU_AND;
         FN_OR:   w_funct_alu = ALU_OR;
         FN_SLT:  w_funct_alu = ALU_SLT;
         default: w_funct_alu = ALU_ADD;
      endcase
   end

   // ---------------------------------------------------------------------
   // Moore output decode. While rst is high the outputs are decoded as if
   // in FETCH; the write strobes are then gated off separately below.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_eff   = rst ? S_FETCH : r_state;
      w_pc_write    = 1'b0;
      w_iord        = 1'b0;
      w_mem_write   = 1'b0;
      w_ir_write    = 1'b0;
      w_reg_dst     = 1'b0;
      w_mem_to_reg  = 1'b0;
      w_reg_write   = 1'b0;
      w_alu_src_a   = 1'b0;
      w_alu_src_b   = 2'b00;
      w_alu_control = 3'b000;
      w_pc_src      = 2'b00;
      w_illegal     = 1'b0;
      case (w_state_eff)
         S_FETCH: begin
            w_ir_write    = 1'b1;
            w_pc_write    = 1'b1;
            w_alu_src_b   = 2'b01;
            w_alu_control = ALU_ADD;
         end
         S_DECODE: begin
            // Branch target precompute: PC+4 + (imm<<2)
            w_alu_src_b   = 2'b11;
            w_alu_control = ALU_ADD;
            w_illegal     = ~w_op_legal;
         end
         S_MEMADR, S_ADDIEX: begin
            w_alu_src_a   = 1'b1;
            w_alu_src_b   = 2'b10;
            w_alu_control = ALU_ADD;
         end
         S_MEMRD: begin
            w_iord = 1'b1;
         end
         S_MEMWB: begin
            w_mem_to_reg = 1'b1;
            w_reg_write  = 1'b1;
         end
         S_MEMWR: begin
            w_iord      = 1'b1;
            w_mem_write = 1'b1;
         end
         S_EXECUTE: begin
            w_alu_src_a   = 1'b1;
            w_alu_control = w_funct_alu;
         end
         S_ALUWB: begin
            w_reg_dst   = 1'b1;
            w_reg_write = 1'b1;
         end
         S_BRANCH: begin
            w_alu_src_a   = 1'b1;
            w_alu_control = ALU_SUB;
            w_pc_src      = 2'b01;
         end
         S_ADDIWB: begin
            w_reg_write = 1'b1;
         end
         S_JUMP: begin
            w_pc_src   = 2'b10;
            w_pc_write = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output assignment; architectural write strobes are blocked in reset
   // ---------------------------------------------------------------------
   assign pc_en       = ~rst & (w_pc_write |
                                ((w_state_eff == S_BRANCH) & w_branch_taken));
   assign ir_write    = ~rst & w_ir_write;
   assign reg_write   = ~rst & w_reg_write;
   assign mem_write   = ~rst & w_mem_write;
   assign iord        = w_iord;
   assign reg_dst     = w_reg_dst;
   assign mem_to_reg  = w_mem_to_reg;
   assign alu_src_a   = w_alu_src_a;
   assign alu_src_b   = w_alu_src_b;
   assign alu_control = w_alu_control;
   assign pc_src      = w_pc_src;
   assign illegal     = w_illegal;
   assign state       = w_state_eff;

endmodule

// File: tb/tb_mips_control_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_control_unit
//
// Scoreboard bench. The driver issues whole instructions; for each cycle of
// an instruction it pushes the expected output vector into a queue. A
// monitor on the falling edge pops one expectation per cycle and compares it
// with the DUT outputs. Expected values come from an instruction-level model:
// the state path of each instruction class and the per-state output table.
// -----------------------------------------------------------------------------
module tb_mips_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_en;
   logic       iord;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_control;
   logic [1:0] pc_src;
   logic       illegal;
   logic [3:0] state;

   always #5 clk = ~clk;

   mips_control_unit #(
      .STATE_WIDTH(4),
      .OPC_WIDTH  (6)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .pc_en      (pc_en),
      .iord       (iord),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_control(alu_control),
      .pc_src     (pc_src),
      .illegal    (illegal),
      .state      (state)
   );

   // Vector: {state, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
   //          reg_write, alu_src_a, alu_src_b, alu_control, pc_src, illegal}
   typedef logic [19:0] vec_t;

   vec_t  exp_q[$];
   string name_q[$];
   int    m_seq[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   logic [5:0] op_tab [0:7];
   logic [5:0] fn_tab [0:4];

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   // State path of one instruction, FETCH first.
   function automatic void build_seq(input logic [5:0] opc);
      m_seq.delete();
      m_seq.push_back(0);
      m_seq.push_back(1);
      case (opc)
         6'b100011: begin m_seq.push_back(2); m_seq.push_back(3); m_seq.push_back(4); end
         6'b101011: begin m_seq.push_back(2); m_seq.push_back(5); end
         6'b000000: begin m_seq.push_back(6); m_seq.push_back(7); end
         6'b001000: begin m_seq.push_back(9); m_seq.push_back(10); end
         6'b000100: m_seq.push_back(8);
         6'b000010: m_seq.push_back(11);
`ifdef MIPS_CU_BNE_EN
         6'b000101: m_seq.push_back(8);
`endif
         default: ;
      endcase
   endfunction

   function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
      if (fn == 6'b100010) return 3'b110;
      if (fn == 6'b100100) return 3'b000;
      if (fn == 6'b100101) return 3'b001;
      if (fn == 6'b101010) return 3'b111;
      return 3'b010;
   endfunction

   function automatic vec_t pack(input int st, input logic pe, io, mw, iw, rd,
                                 m2r, rw, sa, input logic [1:0] sb,
                                 input logic [2:0] ac, input logic [1:0] ps,
                                 input logic il);
      logic [3:0] s4;
      s4 = st[3:0];
      return {s4, pe, io, mw, iw, rd, m2r, rw, sa, sb, ac, ps, il};
   endfunction

   // Expected outputs in state st of an instruction whose path length is len.
   function automatic vec_t exp_vec(input int st, input logic [5:0] opc,
                                    input logic [5:0] fn, input logic z,
                                    input int len);
      logic taken;
      taken = (opc == 6'b000101) ? ~z : z;
      case (st)
         0:  return pack(0, 1,0,0,1,0,0,0,0, 2'b01, 3'b010, 2'b00, 0);
         1:  return pack(1, 0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, (len == 2));
         2:  return pack(2, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0);
         3:  return pack(3, 0,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0);
         4:  return pack(4, 0,0,0,0,0,1,1,0, 2'b00, 3'b000, 2'b00, 0);
         5:  return pack(5, 0,1,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0);
         6:  return pack(6, 0,0,0,0,0,0,0,1, 2'b00, alu_of_funct(fn), 2'b00, 0);
         7:  return pack(7, 0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 0);
         8:  return pack(8, taken,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 0);
         9:  return pack(9, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0);
         10: return pack(10,0,0,0,0,0,0,1,0, 2'b00, 3'b000, 2'b00, 0);
         default: return pack(11,1,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 0);
      endcase
   endfunction

   // ---------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------
   task automatic issue(input logic [5:0] opc, input logic [5:0] fn,
                        input logic z, input int max_states);
      int len;
      build_seq(opc);
      len = m_seq.size();
      opcode = opc;
      funct  = fn;
      zero   = z;
      for (int i = 0; i < len && i < max_states; i++) begin
         exp_q.push_back(exp_vec(m_seq[i], opc, fn, z, len));
         name_q.push_back($sformatf("op%02h_fn%02h_z%0d_step%0d", opc, fn, z, i));
         @(posedge clk);
         #1;
      end
   endtask

   // In reset: FETCH values with every write strobe and pc_en held low.
   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(pack(0, 0,0,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0));
         name_q.push_back($sformatf("reset_cycle%0d", i));
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         vec_t  e;
         vec_t  a;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {state, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_control, pc_src, illegal};
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual %05h required %05h", nm, a, e);
         end else begin
            $display("ok   %s: %05h", nm, a);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      logic [5:0] opc;
      logic [5:0] fn;
      rst    = 1'b1;
      opcode = 6'b000000;
      funct  = 6'b000000;
      zero   = 1'b0;
      op_tab[0] = 6'b100011; op_tab[1] = 6'b101011; op_tab[2] = 6'b000000;
      op_tab[3] = 6'b000100; op_tab[4] = 6'b001000; op_tab[5] = 6'b000010;
      op_tab[6] = 6'b000101; op_tab[7] = 6'b111111;
      fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100010; fn_tab[2] = 6'b100100;
      fn_tab[3] = 6'b100101; fn_tab[4] = 6'b101010;

      @(posedge clk);
      #1;
      do_reset(2);

      // Directed cases
      issue(6'b100011, 6'b000000, 1'b0, 99);   // LW
      issue(6'b000000, 6'b101010, 1'b0, 99);   // R-type slt
      issue(6'b000100, 6'b000000, 1'b1, 99);   // BEQ taken
      issue(6'b000100, 6'b000000, 1'b0, 99);   // BEQ not taken
      issue(6'b111111, 6'b000000, 1'b0, 99);   // unsupported opcode
      issue(6'b101011, 6'b000000, 1'b0, 3);    // SW up to MEMADR ...
      do_reset(3);                             // ... reset lands in MEMWR
      issue(6'b000101, 6'b000000, 1'b0, 99);   // BNE, zero=0
      issue(6'b001000, 6'b000000, 1'b0, 99);   // ADDI
      issue(6'b000010, 6'b000000, 1'b1, 99);   // J
      issue(6'b000000, 6'b111000, 1'b0, 99);   // R-type unknown funct

      // Randomised instruction stream with occasional mid-instruction reset
      for (int k = 0; k < 150; k++) begin
         int pick;
         pick = int'($urandom_range(0, 8));
         if (pick == 8) opc = 6'($urandom_range(0, 63));
         else           opc = op_tab[pick];
         if ($urandom_range(0, 1) == 0) fn = fn_tab[$urandom_range(0, 4)];
         else                           fn = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 14) == 0) begin
            issue(opc, fn, 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
            do_reset(int'($urandom_range(1, 3)));
         end else begin
            issue(opc, fn, 1'($urandom_range(0, 1)), 99);
         end
      end

      // Every pushed expectation must have been consumed by the monitor
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
